// File: rtl/pb_hw_pkg.sv
// Shared types and defaults for the protobuf wire-format decode path.
package pb_hw_pkg;

    localparam int unsigned MAX_VARINT_BYTES_DEF = 10;
    localparam int unsigned LEN_W_DEF            = 32;

    typedef logic [63:0] varint_t;

    typedef enum logic [2:0] {
        WT_VARINT = 3'd0,
        WT_I64    = 3'd1,
        WT_LEN    = 3'd2,
        WT_SGROUP = 3'd3,
        WT_EGROUP = 3'd4,
        WT_I32    = 3'd5
    } wire_type_e;

    typedef enum logic [1:0] {
        ERR_OVERLONG   = 2'd0,
        ERR_BAD_WTYPE  = 2'd1,
        ERR_TRUNCATED  = 2'd2,
        ERR_ZERO_FIELD = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_KEY,
        ST_VARINT,
        ST_FIX,
        ST_LEN,
        ST_EMIT,
        ST_PAYLOAD,
        ST_DRAIN
    } parser_state_e;

endpackage

// File: rtl/pb_field_parser_if.sv
// Byte ingress, field header, payload and error signals of the field parser.
interface pb_field_parser_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;

    logic        fld_valid;
    logic        fld_ready;
    logic [31:0] fld_number;
    logic [2:0]  fld_wtype;
    logic [63:0] fld_value;

    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  pay_data;
    logic        pay_last;

    logic        err;
    logic [1:0]  err_code;

    modport master (
        output in_valid, in_data, in_last, fld_ready, pay_ready,
        input  in_ready, fld_valid, fld_number, fld_wtype, fld_value,
        input  pay_valid, pay_data, pay_last, err, err_code
    );

    modport slave (
        input  in_valid, in_data, in_last, fld_ready, pay_ready,
        output in_ready, fld_valid, fld_number, fld_wtype, fld_value,
        output pay_valid, pay_data, pay_last, err, err_code
    );

endinterface

// File: rtl/pb_varint_acc.sv
// Little-endian base-128 varint accumulator; value/done/overlong include the byte being strobed.
module pb_varint_acc
    import pb_hw_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MAX_VARINT_BYTES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       strobe,
    input  logic [7:0] data,
    output varint_t    value,
    output logic       done,
    output logic       overlong
);

    localparam int unsigned IDX_W = $clog2(MAX_BYTES + 1);

    varint_t          acc_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      shift_amt;

    // Shifts of 64 or more drop the group entirely, which discards bits past bit 63.
    always_comb begin
        shift_amt = 32'(idx_q) * 32'd7;
        value     = acc_q | ({57'd0, data[6:0]} << shift_amt);
        done      = strobe && !data[7];
        overlong  = strobe && data[7] && (idx_q == IDX_W'(MAX_BYTES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            idx_q <= '0;
        end else if (clear || done || overlong) begin
            acc_q <= '0;
            idx_q <= '0;
        end else if (strobe) begin
            acc_q <= value;
            idx_q <= idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/pb_field_parser.sv
// Protobuf wire-format field splitter: key varint, then varint/fixed/length value, then
// zero-latency pass-through of length-delimited payload bytes.
module pb_field_parser
    import pb_hw_pkg::*;
#(
    parameter int unsigned MAX_VARINT_BYTES = MAX_VARINT_BYTES_DEF,
    parameter int unsigned LEN_W            = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    pb_field_parser_if.slave bus
);

    parser_state_e    state_q;
    logic             in_ready;
    logic             in_fire;

    logic             acc_strobe;
    logic             acc_clear;
    logic             acc_done;
    logic             acc_overlong;
    varint_t          acc_value;

    varint_t          fix_q;
    varint_t          fix_next;
    logic [2:0]       fix_cnt_q;
    logic [2:0]       fix_last_q;
    logic             fix_done;

    logic [31:0]      num_q;
    logic [2:0]       wt_q;
    logic [LEN_W-1:0] rem_q;
    logic             key_wt_ok;

    logic             err_hit;
    err_code_e        err_kind;

    logic             fld_valid_q;
    logic [31:0]      fld_number_q;
    logic [2:0]       fld_wtype_q;
    varint_t          fld_value_q;
    logic             err_q;
    err_code_e        err_code_q;

    pb_varint_acc #(.MAX_BYTES(MAX_VARINT_BYTES)) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (acc_clear),
        .strobe   (acc_strobe),
        .data     (bus.in_data),
        .value    (acc_value),
        .done     (acc_done),
        .overlong (acc_overlong)
    );

    assign in_ready = (state_q == ST_PAYLOAD) ? bus.pay_ready : (state_q != ST_EMIT);
    assign in_fire  = bus.in_valid && in_ready;

    assign bus.in_ready   = in_ready;
    assign bus.fld_valid  = fld_valid_q;
    assign bus.fld_number = fld_number_q;
    assign bus.fld_wtype  = fld_wtype_q;
    assign bus.fld_value  = fld_value_q;
    assign bus.pay_valid  = (state_q == ST_PAYLOAD) && bus.in_valid;
    assign bus.pay_data   = (state_q == ST_PAYLOAD) ? bus.in_data : '0;
    assign bus.pay_last   = (state_q == ST_PAYLOAD) && (rem_q == LEN_W'(1));
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;

    // Error detection for the byte on the bus; in_last is only legal on a field's final byte.
    always_comb begin
        acc_strobe = 1'b0;
        err_hit    = 1'b0;
        err_kind   = ERR_OVERLONG;
        key_wt_ok  = acc_value[2:0] inside {WT_VARINT, WT_I64, WT_LEN, WT_I32};
        fix_done   = (fix_cnt_q == fix_last_q);
        fix_next   = fix_q | ({56'd0, bus.in_data} << {fix_cnt_q, 3'b000});
        case (state_q)
            ST_KEY: begin
                acc_strobe = in_fire;
                if (acc_overlong) begin
                    err_hit = 1'b1;
                end else if (acc_done && !key_wt_ok) begin
                    err_hit  = 1'b1;
                    err_kind = ERR_BAD_WTYPE;
                end else if (acc_done && acc_value[34:3] == 32'd0) begin
                    err_hit  = 1'b1;
                    err_kind = ERR_ZERO_FIELD;
                end else if (in_fire && bus.in_last) begin
                    err_hit  = 1'b1;
                    err_kind = ERR_TRUNCATED;
                end
            end
            ST_VARINT: begin
                acc_strobe = in_fire;
                if (acc_overlong) begin
                    err_hit = 1'b1;
                end else if (in_fire && bus.in_last && !acc_done) begin
                    err_hit  = 1'b1;
                    err_kind = ERR_TRUNCATED;
                end
            end
            ST_LEN: begin
                acc_strobe = in_fire;
                if (acc_overlong || (acc_done && (acc_value >> LEN_W) != '0)) begin
                    err_hit = 1'b1;
                end else if (in_fire && bus.in_last && !(acc_done && acc_value == '0)) begin
                    err_hit  = 1'b1;
                    err_kind = ERR_TRUNCATED;
                end
            end
            ST_FIX: begin
                if (in_fire && bus.in_last && !fix_done) begin
                    err_hit  = 1'b1;
                    err_kind = ERR_TRUNCATED;
                end
            end
            ST_PAYLOAD: begin
                if (in_fire && bus.in_last && rem_q != LEN_W'(1)) begin
                    err_hit  = 1'b1;
                    err_kind = ERR_TRUNCATED;
                end
            end
            default: ;
        endcase
        acc_clear = err_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_KEY;
            fix_q        <= '0;
            fix_cnt_q    <= '0;
            fix_last_q   <= '0;
            num_q        <= '0;
            wt_q         <= '0;
            rem_q        <= '0;
            fld_valid_q  <= 1'b0;
            fld_number_q <= '0;
            fld_wtype_q  <= '0;
            fld_value_q  <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_OVERLONG;
        end else begin
            err_q <= 1'b0;
            if (err_hit) begin
                err_q      <= 1'b1;
                err_code_q <= err_kind;
                state_q    <= bus.in_last ? ST_KEY : ST_DRAIN;
            end else begin
                case (state_q)
                    ST_KEY: begin
                        if (acc_done) begin
                            num_q     <= acc_value[34:3];
                            wt_q      <= acc_value[2:0];
                            fix_q     <= '0;
                            fix_cnt_q <= '0;
                            case (acc_value[2:0])
                                WT_VARINT: state_q <= ST_VARINT;
                                WT_LEN:    state_q <= ST_LEN;
                                WT_I64: begin
                                    fix_last_q <= 3'd7;
                                    state_q    <= ST_FIX;
                                end
                                default: begin
                                    fix_last_q <= 3'd3;
                                    state_q    <= ST_FIX;
                                end
                            endcase
                        end
                    end
                    ST_VARINT, ST_LEN: begin
                        if (acc_done) begin
                            fld_valid_q  <= 1'b1;
                            fld_number_q <= num_q;
                            fld_wtype_q  <= wt_q;
                            fld_value_q  <= acc_value;
                            rem_q        <= acc_value[LEN_W-1:0];
                            state_q      <= ST_EMIT;
                        end
                    end
                    ST_FIX: begin
                        if (in_fire) begin
                            fix_q     <= fix_next;
                            fix_cnt_q <= fix_cnt_q + 3'd1;
                            if (fix_done) begin
                                fld_valid_q  <= 1'b1;
                                fld_number_q <= num_q;
                                fld_wtype_q  <= wt_q;
                                fld_value_q  <= fix_next;
                                state_q      <= ST_EMIT;
                            end
                        end
                    end
                    ST_EMIT: begin
                        if (bus.fld_ready) begin
                            fld_valid_q <= 1'b0;
                            state_q     <= (wt_q == 3'(WT_LEN) && rem_q != '0) ? ST_PAYLOAD : ST_KEY;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (in_fire) begin
                            rem_q <= rem_q - LEN_W'(1);
                            if (rem_q == LEN_W'(1)) state_q <= ST_KEY;
                        end
                    end
                    ST_DRAIN: begin
                        if (in_fire && bus.in_last) state_q <= ST_KEY;
                    end
                    default: state_q <= ST_KEY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pb_field_parser.sv
// Directed bench for pb_field_parser: hand-computed field headers, payload bytes and errors.
module tb_pb_field_parser;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] fld_num_q[$];
    logic [2:0]  fld_wt_q[$];
    logic [63:0] fld_val_q[$];
    logic [8:0]  pay_q[$];
    logic [1:0]  err_q[$];
    int          pay_valid_cycles = 0;

    pb_field_parser_if bus();

    pb_field_parser #(.MAX_VARINT_BYTES(10), .LEN_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fld_valid && bus.fld_ready) begin
                fld_num_q.push_back(bus.fld_number);
                fld_wt_q.push_back(bus.fld_wtype);
                fld_val_q.push_back(bus.fld_value);
            end
            if (bus.pay_valid) pay_valid_cycles++;
            if (bus.pay_valid && bus.pay_ready) pay_q.push_back({bus.pay_last, bus.pay_data});
            if (bus.err) err_q.push_back(bus.err_code);
        end
    end

    function automatic logic [98:0] get_fld(input int i);
        if (i < fld_num_q.size()) return {fld_num_q[i], fld_wt_q[i], fld_val_q[i]};
        return '1;
    endfunction

    function automatic logic [8:0] get_pay(input int i);
        if (i < pay_q.size()) return pay_q[i];
        return '1;
    endfunction

    task automatic clear_mon();
        fld_num_q.delete();
        fld_wt_q.delete();
        fld_val_q.delete();
        pay_q.delete();
        err_q.delete();
        pay_valid_cycles = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bq_t b, input bit mark_last);
        int t;
        for (int i = 0; i < b.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            bus.in_last  = mark_last && (i == b.size() - 1);
            t = 0;
            @(negedge clk);
            while (!bus.in_ready && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: byte %0d (%h) in_ready stuck %b, required 1", i, b[i], bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.fld_ready = 1'b1;
        bus.pay_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.fld_valid, bus.pay_valid, bus.pay_last, bus.err} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 10000", {bus.in_ready, bus.fld_valid, bus.pay_valid, bus.pay_last, bus.err});
        end
        n_cmp++;
        if ({bus.fld_number, bus.fld_wtype, bus.fld_value, bus.err_code} !== 101'd0) begin
            n_bad++;
            $display("FAIL reset_fld: got %h required 0", {bus.fld_number, bus.fld_wtype, bus.fld_value, bus.err_code});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_varint();
        bq_t b;
        clear_mon();
        b = {8'h08, 8'h96, 8'h01};
        send(b, 1'b1);
        idle(6);
        n_cmp++;
        if (fld_num_q.size() !== 1) begin
            n_bad++;
            $display("FAIL varint_count: got %0d headers required 1", fld_num_q.size());
        end
        n_cmp++;
        if (get_fld(0) !== {32'd1, 3'd0, 64'd150}) begin
            n_bad++;
            $display("FAIL varint_fld: got %h required %h", get_fld(0), {32'd1, 3'd0, 64'd150});
        end
        n_cmp++;
        if (pay_valid_cycles !== 0 || err_q.size() !== 0) begin
            n_bad++;
            $display("FAIL varint_quiet: pay_valid cycles %0d errs %0d, required 0/0", pay_valid_cycles, err_q.size());
        end
    endtask

    task automatic test_len_payload();
        bq_t b;
        logic [8:0] exp_pay[3] = '{9'h061, 9'h062, 9'h163};
        clear_mon();
        b = {8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
        fork
            send(b, 1'b1);
            begin
                int t = 0;
                @(negedge clk);
                while (!(bus.pay_valid && bus.pay_data == 8'h61) && t < 100) begin
                    t++;
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.pay_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    n_cmp++;
                    if ({bus.pay_valid, bus.pay_data, bus.pay_last, bus.in_ready} !== {1'b1, 8'h62, 1'b0, 1'b0}) begin
                        n_bad++;
                        $display("FAIL pay_stall%0d: valid/data/last/in_ready %b/%h/%b/%b required 1/62/0/0",
                                 k, bus.pay_valid, bus.pay_data, bus.pay_last, bus.in_ready);
                    end
                end
                @(posedge clk);
                #1;
                bus.pay_ready = 1'b1;
            end
        join
        idle(4);
        n_cmp++;
        if (get_fld(0) !== {32'd2, 3'd2, 64'd3} || fld_num_q.size() !== 1) begin
            n_bad++;
            $display("FAIL len_fld: got %h (count %0d) required %h", get_fld(0), fld_num_q.size(), {32'd2, 3'd2, 64'd3});
        end
        n_cmp++;
        if (pay_q.size() !== 3) begin
            n_bad++;
            $display("FAIL pay_count: got %0d bytes required 3", pay_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (get_pay(i) !== exp_pay[i]) begin
                n_bad++;
                $display("FAIL pay_byte%0d: got last/data %h required %h", i, get_pay(i), exp_pay[i]);
            end
        end
    endtask

    task automatic test_fixed();
        bq_t b;
        clear_mon();
        b = {8'h0D, 8'h01, 8'h00, 8'h00, 8'h00, 8'h19,
             8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
        send(b, 1'b1);
        idle(6);
        n_cmp++;
        if (get_fld(0) !== {32'd1, 3'd5, 64'd1}) begin
            n_bad++;
            $display("FAIL fixed32_fld: got %h required %h", get_fld(0), {32'd1, 3'd5, 64'd1});
        end
        n_cmp++;
        if (get_fld(1) !== {32'd3, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF} || fld_num_q.size() !== 2) begin
            n_bad++;
            $display("FAIL fixed64_fld: got %h (count %0d) required %h", get_fld(1), fld_num_q.size(),
                     {32'd3, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF});
        end
    endtask

    task automatic test_overlong();
        bq_t b;
        clear_mon();
        b = {8'h08};
        for (int i = 0; i < 10; i++) b.push_back(8'h80);
        b.push_back(8'h01);
        b.push_back(8'h00);
        send(b, 1'b1);
        b = {8'h10, 8'h05};
        send(b, 1'b1);
        idle(6);
        n_cmp++;
        if (err_q.size() !== 1 || err_q[0] !== 2'd0) begin
            n_bad++;
            $display("FAIL overlong_err: got %0d pulses first code %0d required 1 pulse code 0", err_q.size(), err_q[0]);
        end
        n_cmp++;
        if (get_fld(0) !== {32'd2, 3'd0, 64'd5} || fld_num_q.size() !== 1) begin
            n_bad++;
            $display("FAIL overlong_recover: got %h (count %0d) required %h", get_fld(0), fld_num_q.size(), {32'd2, 3'd0, 64'd5});
        end
        n_cmp++;
        if (bus.err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL overlong_code_held: got %0d required 0", bus.err_code);
        end
    endtask

    task automatic test_bad_wtype();
        bq_t b;
        clear_mon();
        b = {8'h0B, 8'h00};
        send(b, 1'b1);
        idle(4);
        n_cmp++;
        if (err_q.size() !== 1 || err_q[0] !== 2'd1 || fld_num_q.size() !== 0) begin
            n_bad++;
            $display("FAIL bad_wtype: got %0d pulses code %0d headers %0d required 1/1/0", err_q.size(), err_q[0], fld_num_q.size());
        end
        n_cmp++;
        if (bus.err_code !== 2'd1) begin
            n_bad++;
            $display("FAIL bad_wtype_held: got %0d required 1", bus.err_code);
        end
    endtask

    task automatic test_truncated();
        bq_t b;
        clear_mon();
        b = {8'h12, 8'h05, 8'h61};
        send(b, 1'b1);
        idle(4);
        n_cmp++;
        if (err_q.size() !== 1 || err_q[0] !== 2'd2) begin
            n_bad++;
            $display("FAIL truncated_err: got %0d pulses code %0d required 1 pulse code 2", err_q.size(), err_q[0]);
        end
        n_cmp++;
        if (get_fld(0) !== {32'd2, 3'd2, 64'd5} || get_pay(0) !== 9'h061 || pay_q.size() !== 1) begin
            n_bad++;
            $display("FAIL truncated_stream: fld %h pay %h (count %0d) required %h / 061 / 1",
                     get_fld(0), get_pay(0), pay_q.size(), {32'd2, 3'd2, 64'd5});
        end
    endtask

    task automatic test_zero_field();
        bq_t b;
        clear_mon();
        b = {8'h02, 8'h00};
        send(b, 1'b1);
        idle(4);
        n_cmp++;
        if (err_q.size() !== 1 || err_q[0] !== 2'd3 || fld_num_q.size() !== 0) begin
            n_bad++;
            $display("FAIL zero_field: got %0d pulses code %0d headers %0d required 1/3/0", err_q.size(), err_q[0], fld_num_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bq_t b;
        clear_mon();
        b = {8'h08, 8'h01, 8'h10, 8'h02};
        bus.fld_ready = 1'b0;
        fork
            send(b, 1'b1);
            begin
                int t = 0;
                @(negedge clk);
                while (!bus.fld_valid && t < 50) begin
                    t++;
                    @(negedge clk);
                end
                for (int k = 0; k < 4; k++) begin
                    n_cmp++;
                    if ({bus.fld_valid, bus.in_ready, bus.fld_number, bus.fld_wtype, bus.fld_value} !==
                        {1'b1, 1'b0, 32'd1, 3'd0, 64'd1}) begin
                        n_bad++;
                        $display("FAIL fld_hold%0d: valid/in_ready %b/%b fld %h required 1/0 %h", k,
                                 bus.fld_valid, bus.in_ready, {bus.fld_number, bus.fld_wtype, bus.fld_value},
                                 {32'd1, 3'd0, 64'd1});
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.fld_ready = 1'b1;
            end
        join
        idle(6);
        n_cmp++;
        if (get_fld(0) !== {32'd1, 3'd0, 64'd1} || get_fld(1) !== {32'd2, 3'd0, 64'd2} || fld_num_q.size() !== 2) begin
            n_bad++;
            $display("FAIL back_to_back: got %h %h (count %0d) required two headers 1/1 and 2/2",
                     get_fld(0), get_fld(1), fld_num_q.size());
        end
    endtask

    task automatic test_reset_mid_field();
        bq_t b;
        b = {8'h08, 8'h96};
        send(b, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.fld_valid, bus.pay_valid, bus.err, bus.err_code, bus.fld_value} !== {1'b1, 69'd0}) begin
            n_bad++;
            $display("FAIL reset_mid: in_ready/fld_valid/pay_valid/err/code %b%b%b%b/%0d value %h required 1000/0 0",
                     bus.in_ready, bus.fld_valid, bus.pay_valid, bus.err, bus.err_code, bus.fld_value);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        clear_mon();
        b = {8'h08, 8'h96, 8'h01};
        send(b, 1'b1);
        idle(6);
        n_cmp++;
        if (get_fld(0) !== {32'd1, 3'd0, 64'd150} || fld_num_q.size() !== 1 || err_q.size() !== 0) begin
            n_bad++;
            $display("FAIL reset_reparse: got %h (count %0d, errs %0d) required %h", get_fld(0),
                     fld_num_q.size(), err_q.size(), {32'd1, 3'd0, 64'd150});
        end
    endtask

    initial begin
        test_reset();
        test_varint();
        test_len_payload();
        test_fixed();
        test_overlong();
        test_bad_wtype();
        test_truncated();
        test_zero_field();
        test_back_to_back();
        test_reset_mid_field();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
